// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths, load funct3 codes and MMIO addresses
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [XLEN-1:0] MMIO_LED_ADDR = 32'hFFFF_0000;
  localparam logic [XLEN-1:0] MMIO_SW_ADDR  = 32'hFFFF_0004;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchronizer plus stability counter for the switch bus
module sw_debounce #(
  parameter int SW_WIDTH        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] sw_stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SW_WIDTH-1:0] sync_q1;
  logic [SW_WIDTH-1:0] sync_q2;
  logic [CW-1:0]       cnt;

  // Bring the asynchronous switches into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_in;
      sync_q2 <= sync_q1;
    end
  end

  // Commit a new switch value only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sw_stable <= '0;
    end else if (sync_q2 == sw_stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      sw_stable <= sync_q2;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - MEM/WB load path: capture, align, extend, MMIO switch read (option MMIO_LED_READBACK_EN)
module mem_load_unit
  import riscv_pkg::*;
#(
  parameter int SW_WIDTH        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_en,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     dmem_rdata,
  input  logic [SW_WIDTH-1:0] sw_in,
`ifdef MMIO_LED_READBACK_EN
  input  logic [3:0]          leds_in,
`endif
  output logic [XLEN-1:0]     load_data,
  output logic                load_valid,
  output logic                load_misaligned
);

  logic [SW_WIDTH-1:0] sw_stable;
  logic                st_pend;
  logic [1:0]          st_offset;
  logic [2:0]          st_funct3;
  logic                st_is_sw;
`ifdef MMIO_LED_READBACK_EN
  logic                st_is_led;
`endif

  logic [XLEN-1:0] word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  sw_debounce #(
    .SW_WIDTH        (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_stable (sw_stable)
  );

  // MEM-stage capture: remember what the WB-side extraction needs while memory answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_pend   <= 1'b0;
      st_offset <= '0;
      st_funct3 <= '0;
      st_is_sw  <= 1'b0;
`ifdef MMIO_LED_READBACK_EN
      st_is_led <= 1'b0;
`endif
    end else begin
      st_pend <= mem_read_en;
      if (mem_read_en) begin
        st_offset <= alu_result[1:0];
        st_funct3 <= funct3;
        st_is_sw  <= (alu_result == MMIO_SW_ADDR);
`ifdef MMIO_LED_READBACK_EN
        st_is_led <= (alu_result == MMIO_LED_ADDR);
`endif
      end
    end
  end

  // Response cycle: pick the source word, then slice and extend it, or flag misalignment.
  always_comb begin
    word            = dmem_rdata;
    byte_v          = '0;
    half_v          = '0;
    load_data       = '0;
    load_misaligned = 1'b0;
    if (st_is_sw) word = XLEN'(sw_stable);
`ifdef MMIO_LED_READBACK_EN
    if (st_is_led) word = XLEN'(leds_in);
`endif
    if (st_pend) begin
      case (st_funct3)
        F3_BYTE, F3_LBU: begin
          byte_v    = word[{st_offset, 3'b000} +: 8];
          load_data = {{(XLEN-8){byte_v[7] & ~st_funct3[2]}}, byte_v};
        end
        F3_HALF, F3_LHU: begin
          if (st_offset[0]) begin
            load_misaligned = 1'b1;
          end else begin
            half_v    = word[{st_offset[1], 4'b0000} +: 16];
            load_data = {{(XLEN-16){half_v[15] & ~st_funct3[2]}}, half_v};
          end
        end
        default: begin
          if (st_offset != 2'b00) load_misaligned = 1'b1;
          else                    load_data       = word;
        end
      endcase
    end
  end

  assign load_valid = st_pend;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - self-checking bench for mem_load_unit
module tb_mem_load_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [31:0] dmem_rdata;
  logic [3:0]  sw_in;
  logic [3:0]  leds_in;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_load_unit #(.SW_WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read_en     (mem_read_en),
    .alu_result      (alu_result),
    .funct3          (funct3),
    .dmem_rdata      (dmem_rdata),
    .sw_in           (sw_in),
`ifdef MMIO_LED_READBACK_EN
    .leds_in         (leds_in),
`endif
    .load_data       (load_data),
    .load_valid      (load_valid),
    .load_misaligned (load_misaligned)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: slice by shifting and masking the word, extend by adding the upper ones.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int unsigned v;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      return {1'b0, 32'(v)};
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      if (off % 2 == 1) return {1'b1, 32'h0};
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      return {1'b0, 32'(v)};
    end else begin
      if (off != 0) return {1'b1, 32'h0};
      return {1'b0, w};
    end
  endfunction

  // Drive this cycle's inputs just after the edge, then move to the sampling point.
  task automatic cycle_io(input logic req, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    mem_read_en = req;
    funct3      = f3;
    alu_result  = addr;
    dmem_rdata  = rdata;
    @(negedge clk);
  endtask

  task automatic next_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_io(1'b0, 3'b000, 32'h0, 32'h0);
      next_edge();
    end
  endtask

  task automatic single_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_data, input logic exp_mis);
    cycle_io(1'b1, f3, addr, 32'hDEAD_BEEF);
    next_edge();
    cycle_io(1'b0, 3'b000, 32'h0, rdata);
    chk({name, " valid"}, 32'(load_valid), 32'h1);
    chk({name, " data"}, load_data, exp_data);
    chk({name, " mis"}, 32'(load_misaligned), 32'(exp_mis));
    next_edge();
  endtask

  logic        prev_req;
  logic [2:0]  prev_f3;
  logic [1:0]  prev_off;
  logic        req;
  logic [2:0]  f3r;
  logic [31:0] addr_r;
  logic [31:0] rd_r;
  logic [32:0] exp_r;

  initial begin
    vecs[0]  = '{3'b000, 32'h103, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{3'b100, 32'h103, 32'h80FF_1234, 32'h0000_0080, 1'b0};
    vecs[2]  = '{3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0};
    vecs[3]  = '{3'b101, 32'h100, 32'h8001_7FFF, 32'h0000_7FFF, 1'b0};
    vecs[4]  = '{3'b010, 32'h101, 32'h8001_7FFF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{3'b001, 32'h103, 32'h8001_7FFF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{3'b000, 32'h103, 32'h8001_7FFF, 32'hFFFF_FF80, 1'b0};
    vecs[7]  = '{3'b010, 32'h100, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{3'b000, 32'h101, 32'h8001_7FFF, 32'h0000_007F, 1'b0};
    vecs[9]  = '{3'b101, 32'h102, 32'h8001_7FFF, 32'h0000_8001, 1'b0};
    vecs[10] = '{3'b011, 32'h104, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[11] = '{3'b111, 32'h106, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'b001, 32'h101, 32'h1234_5678, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    sw_in = 4'b0000;
    leds_in = 4'h5;
    mem_read_en = 1'b0;
    alu_result = '0;
    funct3 = '0;
    dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle_io(1'b0, 3'b000, 32'h0, 32'hFFFF_FFFF);
    chk("reset valid", 32'(load_valid), 32'h0);
    chk("reset data", load_data, 32'h0);
    chk("reset mis", 32'(load_misaligned), 32'h0);
    next_edge();

    // Directed table, each vector also checks the preceding idle response.
    for (int i = 0; i < 13; i++) begin
      cycle_io(1'b1, vecs[i].f3, vecs[i].addr, 32'hDEAD_BEEF);
      chk($sformatf("vec%0d idle valid", i), 32'(load_valid), 32'h0);
      chk($sformatf("vec%0d idle data", i), load_data, 32'h0);
      next_edge();
      cycle_io(1'b0, 3'b000, 32'h0, vecs[i].rdata);
      chk($sformatf("vec%0d valid", i), 32'(load_valid), 32'h1);
      chk($sformatf("vec%0d data", i), load_data, vecs[i].exp_data);
      chk($sformatf("vec%0d mis", i), 32'(load_misaligned), 32'(vecs[i].exp_mis));
      next_edge();
    end

    // Back-to-back words.
    cycle_io(1'b1, F3_WORD, 32'h0, 32'h0);
    next_edge();
    cycle_io(1'b1, F3_WORD, 32'h4, 32'h11);
    chk("b2b0 valid", 32'(load_valid), 32'h1);
    chk("b2b0 data", load_data, 32'h11);
    next_edge();
    cycle_io(1'b1, F3_WORD, 32'h8, 32'h22);
    chk("b2b1 valid", 32'(load_valid), 32'h1);
    chk("b2b1 data", load_data, 32'h22);
    next_edge();
    cycle_io(1'b0, 3'b000, 32'h0, 32'h33);
    chk("b2b2 valid", 32'(load_valid), 32'h1);
    chk("b2b2 data", load_data, 32'h33);
    next_edge();
    cycle_io(1'b0, 3'b000, 32'h0, 32'h44);
    chk("b2b end valid", 32'(load_valid), 32'h0);
    next_edge();

    // Randomized pipeline against the reference model.
    prev_req = 1'b0;
    prev_f3 = '0;
    prev_off = '0;
    for (int i = 0; i < 300; i++) begin
      req    = 1'($urandom_range(0, 3) != 0);
      f3r    = 3'($urandom_range(0, 7));
      addr_r = $urandom & 32'h0000_FFFF;
      rd_r   = $urandom;
      cycle_io(req, f3r, addr_r, rd_r);
      exp_r = prev_req ? ref_load(prev_f3, prev_off, rd_r) : 33'h0;
      chk($sformatf("rnd%0d valid", i), 32'(load_valid), 32'(prev_req));
      chk($sformatf("rnd%0d data", i), load_data, exp_r[31:0]);
      chk($sformatf("rnd%0d mis", i), 32'(load_misaligned), 32'(exp_r[32]));
      prev_req = req;
      prev_f3  = f3r;
      prev_off = addr_r[1:0];
      next_edge();
    end
    idle_cycles(1);

    // Switch path.
    single_load("sw after reset", F3_WORD, MMIO_SW_ADDR, 32'h7777_7777, 32'h0, 1'b0);
    sw_in = 4'b1010;
    idle_cycles(20);
    single_load("sw 1010", F3_WORD, MMIO_SW_ADDR, 32'h7777_7777, 32'h0000_000A, 1'b0);
    sw_in = 4'b1111;
    idle_cycles(5);
    sw_in = 4'b1010;
    idle_cycles(25);
    single_load("sw glitch", F3_WORD, MMIO_SW_ADDR, 32'h7777_7777, 32'h0000_000A, 1'b0);
    single_load("sw lb", F3_BYTE, MMIO_SW_ADDR, 32'hFFFF_FFFF, 32'h0000_000A, 1'b0);
    sw_in = 4'b0011;
    idle_cycles(20);
    single_load("sw 0011", F3_LHU, MMIO_SW_ADDR, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);

`ifdef MMIO_LED_READBACK_EN
    single_load("led read", F3_WORD, MMIO_LED_ADDR, 32'h1357_9BDF, 32'h0000_0005, 1'b0);
`else
    single_load("led addr dmem", F3_WORD, MMIO_LED_ADDR, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
`endif

    // Reset while a load is in flight.
    mem_read_en = 1'b1;
    funct3 = F3_WORD;
    alu_result = 32'h200;
    rst = 1'b1;
    next_edge();
    rst = 1'b0;
    cycle_io(1'b0, 3'b000, 32'h0, 32'h5555_5555);
    chk("rst drop valid", 32'(load_valid), 32'h0);
    chk("rst drop data", load_data, 32'h0);
    next_edge();
    single_load("sw cleared", F3_WORD, MMIO_SW_ADDR, 32'h7777_7777, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
